// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync/blank decode, frame pulses and count.
// Latency: 0 advances; every output is registered on the same edge that moves the counters.
// Backpressure: none; pix_ena gates advances, levels hold and pulses stay low while it is 0.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int COL_WIDTH   = 10,
    parameter int ROW_WIDTH   = 9,
    parameter int FRAME_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pix_ena,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic                   disp_ena,
    output logic [COL_WIDTH-1:0]   col,
    output logic [ROW_WIDTH-1:0]   row,
    output logic                   end_line,
    output logic                   end_frame,
    output logic                   start_frame,
    output logic [FRAME_WIDTH-1:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Inclusive bounds so no constant ever needs to hold H_TOTAL itself
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_LAST   = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_LAST   = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [HW-1:0]          h_cnt_q, h_cnt_d, h_nxt;
    logic [VW-1:0]          v_cnt_q, v_cnt_d, v_nxt;
    logic                   h_vis, v_vis;
    logic                   h_sync_q, h_sync_d;
    logic                   v_sync_q, v_sync_d;
    logic                   disp_ena_q, disp_ena_d;
    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic                   end_line_q, end_line_d;
    logic                   end_frame_q, end_frame_d;
    logic                   start_frame_q, start_frame_d;
    logic [FRAME_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        h_nxt = h_cnt_q + HW'(1);
        v_nxt = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    assign h_vis = (h_nxt <= H_VIS_LAST);
    assign v_vis = (v_nxt <= V_VIS_LAST);

    // Decode the position being entered so outputs line up with the counters
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        disp_ena_d    = disp_ena_q;
        col_d         = col_q;
        row_d         = row_q;
        frame_cnt_d   = frame_cnt_q;
        end_line_d    = 1'b0;
        end_frame_d   = 1'b0;
        start_frame_d = 1'b0;
        if (pix_ena) begin
            h_cnt_d       = h_nxt;
            v_cnt_d       = v_nxt;
            h_sync_d      = (h_nxt >= H_SYNC_FIRST && h_nxt <= H_SYNC_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_d      = (v_nxt >= V_SYNC_FIRST && v_nxt <= V_SYNC_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
            disp_ena_d    = h_vis && v_vis;
            col_d         = h_vis ? COL_WIDTH'(h_nxt) : '0;
            row_d         = v_vis ? ROW_WIDTH'(v_nxt) : '0;
            end_line_d    = (h_nxt == H_LAST);
            end_frame_d   = (h_nxt == H_LAST) && (v_nxt == V_LAST);
            start_frame_d = (h_nxt == '0) && (v_nxt == '0);
            if (start_frame_d) begin
                frame_cnt_d = frame_cnt_q + FRAME_WIDTH'(1);
            end
        end
    end

    // Reset parks on the last pixel so the first advance lands on (0,0)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            h_sync_q      <= ~H_SYNC_POL;
            v_sync_q      <= ~V_SYNC_POL;
            disp_ena_q    <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            end_line_q    <= 1'b0;
            end_frame_q   <= 1'b0;
            start_frame_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            disp_ena_q    <= disp_ena_d;
            col_q         <= col_d;
            row_q         <= row_d;
            end_line_q    <= end_line_d;
            end_frame_q   <= end_frame_d;
            start_frame_q <= start_frame_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign disp_ena    = disp_ena_q;
    assign col         = col_q;
    assign row         = row_q;
    assign end_line    = end_line_q;
    assign end_frame   = end_frame_q;
    assign start_frame = start_frame_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, mid-size (48x30) and small (14x7, active-high) instances.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic pix_ena;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // default 640x480 instance
    logic       d_h_sync, d_v_sync, d_disp_ena, d_end_line, d_end_frame, d_start_frame;
    logic [9:0] d_col;
    logic [8:0] d_row;
    logic [7:0] d_frame_cnt;

    // mid-size instance: H 32/4/8/4 (48), V 24/2/2/2 (30), 1440 per frame
    logic       m_h_sync, m_v_sync, m_disp_ena, m_end_line, m_end_frame, m_start_frame;
    logic [4:0] m_col;
    logic [4:0] m_row;
    logic [7:0] m_frame_cnt;

    // small instance: H 8/2/2/2 (14), V 4/1/1/1 (7), active-high syncs, 2-bit frame count
    logic       s_h_sync, s_v_sync, s_disp_ena, s_end_line, s_end_frame, s_start_frame;
    logic [2:0] s_col;
    logic [1:0] s_row;
    logic [1:0] s_frame_cnt;

    vga_timing_gen u_dflt (
        .clk(clk), .reset_n(reset_n), .pix_ena(pix_ena),
        .h_sync(d_h_sync), .v_sync(d_v_sync), .disp_ena(d_disp_ena),
        .col(d_col), .row(d_row), .end_line(d_end_line), .end_frame(d_end_frame),
        .start_frame(d_start_frame), .frame_cnt(d_frame_cnt)
    );

    vga_timing_gen #(
        .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .COL_WIDTH(5), .ROW_WIDTH(5), .FRAME_WIDTH(8)
    ) u_mid (
        .clk(clk), .reset_n(reset_n), .pix_ena(pix_ena),
        .h_sync(m_h_sync), .v_sync(m_v_sync), .disp_ena(m_disp_ena),
        .col(m_col), .row(m_row), .end_line(m_end_line), .end_frame(m_end_frame),
        .start_frame(m_start_frame), .frame_cnt(m_frame_cnt)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .COL_WIDTH(3), .ROW_WIDTH(2), .FRAME_WIDTH(2)
    ) u_small (
        .clk(clk), .reset_n(reset_n), .pix_ena(pix_ena),
        .h_sync(s_h_sync), .v_sync(s_v_sync), .disp_ena(s_disp_ena),
        .col(s_col), .row(s_row), .end_line(s_end_line), .end_frame(s_end_frame),
        .start_frame(s_start_frame), .frame_cnt(s_frame_cnt)
    );

    // Leaves every instance sampled just after its first advance, at (0,0)
    task automatic reset_dut();
        reset_n = 1'b0;
        pix_ena = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pix_ena = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (d_h_sync !== 1'b1) begin failures++; $display("FAIL rst_hsync got=%0b exp=1", d_h_sync); end
        checks++; if (d_v_sync !== 1'b1) begin failures++; $display("FAIL rst_vsync got=%0b exp=1", d_v_sync); end
        checks++; if (d_disp_ena !== 1'b0) begin failures++; $display("FAIL rst_disp got=%0b exp=0", d_disp_ena); end
        checks++; if (d_col !== 10'd0 || d_row !== 9'd0) begin failures++; $display("FAIL rst_colrow got=%0d,%0d exp=0,0", d_col, d_row); end
        checks++; if ({d_end_line, d_end_frame, d_start_frame} !== 3'b000) begin failures++; $display("FAIL rst_pulses got=%b exp=000", {d_end_line, d_end_frame, d_start_frame}); end
        checks++; if (d_frame_cnt !== 8'd0) begin failures++; $display("FAIL rst_fcnt got=%0d exp=0", d_frame_cnt); end
        checks++; if ({s_h_sync, s_v_sync} !== 2'b00) begin failures++; $display("FAIL rst_small_sync got=%b exp=00", {s_h_sync, s_v_sync}); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (d_col !== 10'd0 || d_row !== 9'd0) begin failures++; $display("FAIL first_colrow got=%0d,%0d exp=0,0", d_col, d_row); end
        checks++; if (d_disp_ena !== 1'b1) begin failures++; $display("FAIL first_disp got=%0b exp=1", d_disp_ena); end
        checks++; if (d_start_frame !== 1'b1) begin failures++; $display("FAIL first_sof got=%0b exp=1", d_start_frame); end
        checks++; if (d_frame_cnt !== 8'd1) begin failures++; $display("FAIL first_fcnt got=%0d exp=1", d_frame_cnt); end
        checks++; if (d_h_sync !== 1'b1) begin failures++; $display("FAIL first_hsync got=%0b exp=1", d_h_sync); end
        @(posedge clk); #1;
        checks++; if (d_start_frame !== 1'b0) begin failures++; $display("FAIL sof_width got=%0b exp=0", d_start_frame); end
        checks++; if (d_col !== 10'd1 || d_frame_cnt !== 8'd1) begin failures++; $display("FAIL second_adv got col=%0d fcnt=%0d exp col=1 fcnt=1", d_col, d_frame_cnt); end
    endtask

    task automatic test_line();
        int n_disp = 0, n_hs = 0, hs_first = -1, hs_last = -1, n_el = 0, el_at = -1, col_err = 0;
        reset_dut();
        for (int p = 0; p < 800; p++) begin
            if (d_disp_ena) n_disp++;
            if (!d_h_sync) begin n_hs++; if (hs_first < 0) hs_first = p; hs_last = p; end
            if (d_end_line) begin n_el++; el_at = p; end
            if (d_col !== ((p < 640) ? 10'(p) : 10'd0)) col_err++;
            @(posedge clk); #1;
        end
        checks++; if (n_disp !== 640) begin failures++; $display("FAIL line_disp_cnt got=%0d exp=640", n_disp); end
        checks++; if (n_hs !== 96) begin failures++; $display("FAIL line_hsync_cnt got=%0d exp=96", n_hs); end
        checks++; if (hs_first !== 656 || hs_last !== 751) begin failures++; $display("FAIL line_hsync_span got=%0d..%0d exp=656..751", hs_first, hs_last); end
        checks++; if (n_el !== 1 || el_at !== 799) begin failures++; $display("FAIL line_eol got cnt=%0d at=%0d exp cnt=1 at=799", n_el, el_at); end
        checks++; if (col_err !== 0) begin failures++; $display("FAIL line_col_track got=%0d errors exp=0", col_err); end
        checks++; if (d_col !== 10'd0 || d_row !== 9'd1 || d_disp_ena !== 1'b1 || d_end_line !== 1'b0) begin
            failures++; $display("FAIL line_wrap got col=%0d row=%0d disp=%0b eol=%0b exp 0,1,1,0", d_col, d_row, d_disp_ena, d_end_line); end
    endtask

    task automatic test_half_rate();
        int n_disp = 0, n_hs = 0, n_el = 0, el_at = -1, n_sf = 0, col_err = 0;
        reset_dut();
        for (int c = 0; c < 1600; c++) begin
            if (d_disp_ena) n_disp++;
            if (!d_h_sync) n_hs++;
            if (d_end_line) begin n_el++; el_at = c; end
            if (d_start_frame) n_sf++;
            if (d_col !== ((c / 2 < 640) ? 10'(c / 2) : 10'd0)) col_err++;
            pix_ena = (c % 2 == 1);
            @(posedge clk); #1;
        end
        pix_ena = 1'b1;
        checks++; if (n_disp !== 1280) begin failures++; $display("FAIL half_disp_cnt got=%0d exp=1280", n_disp); end
        checks++; if (n_hs !== 192) begin failures++; $display("FAIL half_hsync_cnt got=%0d exp=192", n_hs); end
        checks++; if (n_el !== 1 || el_at !== 1598) begin failures++; $display("FAIL half_eol got cnt=%0d at=%0d exp cnt=1 at=1598", n_el, el_at); end
        checks++; if (n_sf !== 1) begin failures++; $display("FAIL half_sof_width got=%0d exp=1", n_sf); end
        checks++; if (col_err !== 0) begin failures++; $display("FAIL half_col_hold got=%0d errors exp=0", col_err); end
        checks++; if (d_col !== 10'd0 || d_row !== 9'd1) begin failures++; $display("FAIL half_wrap got col=%0d row=%0d exp 0,1", d_col, d_row); end
    endtask

    task automatic test_frame();
        int n_vs = 0, vs_first = -1, vs_last = -1, n_ef = 0, ef_at = -1, n_sf = 0, sf_at = -1;
        int fc_at_sf = -1, col_max = 0, row_max = 0, n_disp = 0;
        reset_dut();
        for (int p = 0; p <= 1440; p++) begin
            if (!m_v_sync) begin n_vs++; if (vs_first < 0) vs_first = p; vs_last = p; end
            if (m_end_frame) begin n_ef++; ef_at = p; end
            if (p > 0 && m_start_frame) begin n_sf++; sf_at = p; fc_at_sf = int'(m_frame_cnt); end
            if (int'(m_col) > col_max) col_max = int'(m_col);
            if (int'(m_row) > row_max) row_max = int'(m_row);
            if (p < 1440 && m_disp_ena) n_disp++;
            @(posedge clk); #1;
        end
        checks++; if (n_vs !== 96) begin failures++; $display("FAIL frame_vsync_cnt got=%0d exp=96", n_vs); end
        checks++; if (vs_first !== 1248 || vs_last !== 1343) begin failures++; $display("FAIL frame_vsync_span got=%0d..%0d exp=1248..1343", vs_first, vs_last); end
        checks++; if (n_ef !== 1 || ef_at !== 1439) begin failures++; $display("FAIL frame_eof got cnt=%0d at=%0d exp cnt=1 at=1439", n_ef, ef_at); end
        checks++; if (n_sf !== 1 || sf_at !== 1440) begin failures++; $display("FAIL frame_sof got cnt=%0d at=%0d exp cnt=1 at=1440", n_sf, sf_at); end
        checks++; if (fc_at_sf !== 2) begin failures++; $display("FAIL frame_fcnt got=%0d exp=2", fc_at_sf); end
        checks++; if (col_max !== 31 || row_max !== 23) begin failures++; $display("FAIL frame_colrow_max got=%0d,%0d exp=31,23", col_max, row_max); end
        checks++; if (n_disp !== 768) begin failures++; $display("FAIL frame_disp_cnt got=%0d exp=768", n_disp); end
    endtask

    task automatic test_small();
        int n_hs = 0, hs_first = -1, n_vs = 0, vs_first = -1, ef_at = -1, n_sf = 0, n_disp = 0;
        int sf_pos [4];
        int sf_fc [4];
        reset_dut();
        for (int p = 0; p <= 294; p++) begin
            if (s_start_frame) begin
                if (n_sf < 4) begin sf_pos[n_sf] = p; sf_fc[n_sf] = int'(s_frame_cnt); end
                n_sf++;
            end
            if (p < 98) begin
                if (s_h_sync) begin n_hs++; if (hs_first < 0) hs_first = p; end
                if (s_v_sync) begin n_vs++; if (vs_first < 0) vs_first = p; end
                if (s_end_frame) ef_at = p;
                if (s_disp_ena) n_disp++;
            end
            @(posedge clk); #1;
        end
        checks++; if (n_hs !== 14 || hs_first !== 10) begin failures++; $display("FAIL small_hsync got cnt=%0d first=%0d exp cnt=14 first=10", n_hs, hs_first); end
        checks++; if (n_vs !== 14 || vs_first !== 70) begin failures++; $display("FAIL small_vsync got cnt=%0d first=%0d exp cnt=14 first=70", n_vs, vs_first); end
        checks++; if (ef_at !== 97) begin failures++; $display("FAIL small_eof got=%0d exp=97", ef_at); end
        checks++; if (n_disp !== 32) begin failures++; $display("FAIL small_disp_cnt got=%0d exp=32", n_disp); end
        checks++; if (n_sf !== 4) begin failures++; $display("FAIL small_sof_cnt got=%0d exp=4", n_sf); end
        checks++; if (n_sf >= 4 && (sf_pos[1] !== 98 || sf_pos[3] !== 294)) begin failures++; $display("FAIL small_frame_len got=%0d,%0d exp=98,294", sf_pos[1], sf_pos[3]); end
        checks++; if (n_sf >= 4 && (sf_fc[0] !== 1 || sf_fc[1] !== 2 || sf_fc[2] !== 3 || sf_fc[3] !== 0)) begin
            failures++; $display("FAIL small_fcnt_wrap got=%0d,%0d,%0d,%0d exp=1,2,3,0", sf_fc[0], sf_fc[1], sf_fc[2], sf_fc[3]); end
    endtask

    task automatic test_midframe_reset();
        reset_dut();
        repeat (990) begin @(posedge clk); #1; end
        checks++; if (m_col !== 5'd30 || m_row !== 5'd20 || m_disp_ena !== 1'b1) begin
            failures++; $display("FAIL mid_position got col=%0d row=%0d disp=%0b exp 30,20,1", m_col, m_row, m_disp_ena); end
        reset_n = 1'b0;
        #2;
        checks++; if (m_col !== 5'd0 || m_row !== 5'd0 || m_disp_ena !== 1'b0) begin
            failures++; $display("FAIL mid_async_rst got col=%0d row=%0d disp=%0b exp 0,0,0", m_col, m_row, m_disp_ena); end
        checks++; if (m_frame_cnt !== 8'd0 || m_h_sync !== 1'b1 || d_frame_cnt !== 8'd0) begin
            failures++; $display("FAIL mid_async_rst_lvl got fcnt=%0d hsync=%0b dfcnt=%0d exp 0,1,0", m_frame_cnt, m_h_sync, d_frame_cnt); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_col !== 5'd0 || m_row !== 5'd0 || m_start_frame !== 1'b1 || m_frame_cnt !== 8'd1) begin
            failures++; $display("FAIL mid_restart got col=%0d row=%0d sof=%0b fcnt=%0d exp 0,0,1,1", m_col, m_row, m_start_frame, m_frame_cnt); end
    endtask

    initial begin
        reset_n = 1'b0;
        pix_ena = 1'b0;
        test_reset();
        test_line();
        test_half_rate();
        test_frame();
        test_small();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
